// File: rtl/booth_seq_ctrl.sv
// Sequencing FSM for a radix-2 Booth multiplier datapath.
// Flow: IDLE -> LOAD -> (EVAL -> SHIFT) x N -> OUT -> DONE -> IDLE.
// Outputs decode from the registered state. The one exception is
// alu_op/alu_en in EVAL, which follow the Booth pair {q0, q_m1}
// combinationally; the datapath holds those bits stable during EVAL.
// Handshake: start is a level that is sampled only in IDLE. There is no
// ready/ack, and a start seen while busy or in DONE is dropped. abort
// cancels at the next edge in any non-IDLE state.
module booth_seq_ctrl #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          q0,
  input  logic          q_m1,
  output logic          ld_ops,
  output logic          alu_en,
  output logic [1:0]    alu_op,
  output logic          shift_en,
  output logic          load_out,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] iter_cnt,
  output logic [2:0]    o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    OUT   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_iter_cnt;
  logic [CW-1:0] w_next_cnt;

  // State and iteration counter registers. An asynchronous reset drops any
  // operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_iter_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_iter_cnt <= w_next_cnt;
    end
  end

  // Next-state and counter logic. abort outranks every other transition
  // outside IDLE.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_iter_cnt;
    unique case (r_state)
      IDLE: begin
        if (start) w_next_state = LOAD;
      end
      LOAD: begin
        w_next_state = EVAL;
        w_next_cnt   = CW'(N);
      end
      EVAL: begin
        w_next_state = SHIFT;
      end
      SHIFT: begin
        w_next_cnt   = r_iter_cnt - CW'(1);
        w_next_state = (r_iter_cnt == CW'(1)) ? OUT : EVAL;
      end
      OUT: begin
        w_next_state = DONE;
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end
    endcase
    if (abort && (r_state != IDLE)) begin
      w_next_state = IDLE;
      w_next_cnt   = '0;
    end
  end

  // Output decode. Only EVAL looks at the Booth pair; every other output is
  // a pure function of the state.
  always_comb begin
    ld_ops   = 1'b0;
    alu_en   = 1'b0;
    alu_op   = 2'b00;
    shift_en = 1'b0;
    load_out = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      IDLE: begin
      end
      LOAD: begin
        ld_ops = 1'b1;
        busy   = 1'b1;
      end
      EVAL: begin
        busy = 1'b1;
        case ({q0, q_m1})
          2'b10: begin
            alu_op = 2'b10;
            alu_en = 1'b1;
          end
          2'b01: begin
            alu_op = 2'b01;
            alu_en = 1'b1;
          end
          default: begin
            alu_op = 2'b00;
            alu_en = 1'b0;
          end
        endcase
      end
      SHIFT: begin
        shift_en = 1'b1;
        busy     = 1'b1;
      end
      OUT: begin
        load_out = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign iter_cnt    = r_iter_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl. A vector table drives N=8 operations
// and checks the outputs cycle by cycle. Hand-written sequences then cover
// reset, start held high, and an N=4 build.
module tb_booth_seq_ctrl;

  localparam int N   = 8;
  localparam int CW  = $clog2(N + 1);
  localparam int N4  = 4;
  localparam int CW4 = $clog2(N4 + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N=8 DUT signals
  logic          start, abort, q0, q_m1;
  logic          ld_ops, alu_en, shift_en, load_out, busy, done;
  logic [1:0]    alu_op;
  logic [CW-1:0] iter_cnt;
  logic [2:0]    dbg_state;

  // N=4 DUT signals
  logic           start4, abort4, q0_4, q_m1_4;
  logic           ld_ops4, alu_en4, shift_en4, load_out4, busy4, done4;
  logic [1:0]     alu_op4;
  logic [CW4-1:0] iter_cnt4;
  logic [2:0]     dbg_state4;

  booth_seq_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .q0(q0), .q_m1(q_m1),
    .ld_ops(ld_ops), .alu_en(alu_en), .alu_op(alu_op), .shift_en(shift_en),
    .load_out(load_out), .busy(busy), .done(done), .iter_cnt(iter_cnt),
    .o_dbg_state(dbg_state)
  );

  booth_seq_ctrl #(.N(N4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4), .q0(q0_4), .q_m1(q_m1_4),
    .ld_ops(ld_ops4), .alu_en(alu_en4), .alu_op(alu_op4), .shift_en(shift_en4),
    .load_out(load_out4), .busy(busy4), .done(done4), .iter_cnt(iter_cnt4),
    .o_dbg_state(dbg_state4)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  // {ld_ops, alu_en, alu_op[1:0], shift_en, load_out, busy, done, iter_cnt}
  function automatic logic [7+CW:0] pack8();
    return {ld_ops, alu_en, alu_op, shift_en, load_out, busy, done, iter_cnt};
  endfunction

  task automatic check(input string name, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, exp);
    end
  endtask

  // ---------------- vector table ----------------
  // ops: hand-computed alu_op per iteration k at bits [2k-1:2k-2].
  // abort_cyc / start_cyc: cycle after E0 in which abort / an extra start
  // pulse is asserted (0 = none).
  typedef struct {
    logic [7:0]  mult;
    logic [15:0] ops;
    int          abort_cyc;
    int          start_cyc;
  } vec_t;

  vec_t vecs[9];

  // ---------------- driver tasks ----------------
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Bench model of the datapath Q shifting: iteration k presents
  // q0 = bit k-1 of the multiplier and q_m1 = bit k-2 (0 for k = 1).
  task automatic drive_q(input logic [7:0] mult, input int cyc);
    int k;
    k = cyc / 2;
    if (cyc >= 2 && k >= 1 && k <= N) begin
      q0   = mult[k-1];
      q_m1 = (k == 1) ? 1'b0 : mult[k-2];
    end else begin
      q0   = 1'b0;
      q_m1 = 1'b0;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [7+CW:0] exp;
    logic          act, ev, sh;
    int            k;
    start = 1'b1;
    after_edge();             // E0 samples start
    start = 1'b0;
    for (int c = 1; c <= 2*N + 4; c++) begin
      drive_q(v.mult, c);
      abort = (c == v.abort_cyc);
      start = (c == v.start_cyc);
      act = (v.abort_cyc == 0) || (c <= v.abort_cyc);
      ev  = act && (c % 2 == 0) && (c >= 2) && (c <= 2*N);
      sh  = act && (c % 2 == 1) && (c >= 3) && (c <= 2*N + 1);
      k   = c / 2;
      exp = '0;
      exp[7+CW]   = act && (c == 1);
      exp[5+CW:4+CW] = ev ? v.ops[2*k-1 -: 2] : 2'b00;
      exp[6+CW]   = ev && (v.ops[2*k-1 -: 2] != 2'b00);
      exp[3+CW]   = sh;
      exp[2+CW]   = act && (c == 2*N + 2);
      exp[1+CW]   = act && (c >= 1) && (c <= 2*N + 2);
      exp[CW]     = act && (c == 2*N + 3);
      exp[CW-1:0] = (ev || sh) ? CW'(N - k + 1) : '0;
      @(negedge clk);
      check($sformatf("vec%0d", idx), c, 32'(pack8()), 32'(exp));
      after_edge();
    end
    abort = 1'b0;
    start = 1'b0;
    q0    = 1'b0;
    q_m1  = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{8'h00, 16'h0000, 0,  0};
    vecs[1] = '{8'h55, 16'h6666, 0,  0};
    vecs[2] = '{8'hFF, 16'h0002, 0,  5};
    vecs[3] = '{8'h0F, 16'h0102, 0,  0};
    vecs[4] = '{8'h55, 16'h6666, 6,  3};   // abort in EVAL k=3
    vecs[5] = '{8'h55, 16'h6666, 18, 0};   // abort in OUT
    vecs[6] = '{8'h00, 16'h0000, 1,  0};   // abort in LOAD
    vecs[7] = '{8'hFF, 16'h0002, 0, 19};   // start in DONE ignored
    vecs[8] = '{8'h0F, 16'h0102, 19, 0};   // abort in DONE

    rst = 1'b0;
    start = 1'b0; abort = 1'b0; q0 = 1'b0; q_m1 = 1'b0;
    start4 = 1'b0; abort4 = 1'b0; q0_4 = 1'b0; q_m1_4 = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out", 0, 32'(pack8()), 32'd0);
    check("reset_out4", 0, 32'({ld_ops4, alu_en4, alu_op4, shift_en4, load_out4, busy4, done4, iter_cnt4}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_state", 0, 32'(dbg_state), 32'd0);
    check("idle_out", 0, 32'(pack8()), 32'd0);
    after_edge();

    // table-driven operations
    for (int i = 0; i < 9; i++) begin
      run_vec(i, vecs[i]);
    end

    // async reset between edges in EVAL of iteration 3 (cycle 6)
    start = 1'b1;
    after_edge();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      drive_q(8'h55, c);
      after_edge();
    end
    drive_q(8'h55, 6);
    #3 rst = 1'b0;
    #1 check("async_rst_out", 6, 32'(pack8()), 32'd0);
    #2 rst = 1'b1;
    q0 = 1'b0; q_m1 = 1'b0;
    after_edge();
    for (int c = 7; c <= 2*N + 4; c++) begin
      @(negedge clk);
      check("post_rst", c, 32'({dbg_state, pack8()}), 32'd0);
      after_edge();
    end

    // start held high across two operations
    start = 1'b1;
    after_edge();
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      check("held_start", c, 32'({ld_ops, done, busy}),
            32'({(c == 1 || c == 21), (c == 19), ((c <= 18) || (c >= 21))}));
      after_edge();
    end
    start = 1'b0;
    abort = 1'b1;
    after_edge();
    abort = 1'b0;
    @(negedge clk);
    check("held_abort", 0, 32'({dbg_state, busy}), 32'd0);
    after_edge();

    // N=4 build with Booth pair 11 throughout
    q0_4 = 1'b1; q_m1_4 = 1'b1;
    start4 = 1'b1;
    after_edge();
    start4 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check("n4", c, 32'({alu_en4, alu_op4, load_out4, done4, busy4, ld_ops4}),
            32'({1'b0, 2'b00, (c == 10), (c == 11), (c <= 10), (c == 1)}));
      after_edge();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_seq_ctrl.md
Name: booth_seq_ctrl

Overview:
Sequencing FSM for the radix-2 Booth multiplier datapath. It accepts a start request, loads the operand registers, and runs N evaluate/shift iterations. During each evaluate cycle it issues add, subtract or no-op from the Booth pair {Q0, Q-1}. At the end it pulses the load strobe of the output subsystem (ss_salida) and signals completion. Sits between the input subsystem / top-level control and the arithmetic datapath.

Parameters:
N, 8, operand width in bits = number of Booth iterations (N >= 2)
CW, $clog2(N+1), iteration counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request a multiplication; sampled only in IDLE
abort  input  1  synchronous cancel; effective in any non-IDLE state
q0  input  1  LSB of datapath Q register
q_m1  input  1  datapath Q-1 bit
ld_ops  output  1  load M and Q, clear A and Q-1 (one-cycle pulse)
alu_en  output  1  write ALU result into A this cycle
alu_op  output  2  00 none, 01 A+M, 10 A-M (11 never driven)
shift_en  output  1  arithmetic right shift of {A,Q,Q-1}
load_out  output  1  one-cycle pulse to the output subsystem load input
busy  output  1  high from LOAD through OUT inclusive
done  output  1  one-cycle completion pulse
iter_cnt  output  CW  remaining iterations

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE, iter_cnt = 0.
  - All outputs 0 immediately, regardless of clk.
  - Reset mid-operation discards the operation: no load_out, no done.
- States: IDLE, LOAD, EVAL, SHIFT, OUT, DONE. Registered state; outputs decode from state.
- Exception: alu_op/alu_en in EVAL are a combinational function of q0/q_m1. The datapath holds these bits stable during EVAL.
- IDLE: start=1 at a clock edge -> LOAD. Otherwise stay in IDLE.
- LOAD: ld_ops=1, iter_cnt <= N; -> EVAL.
- EVAL:
  - {q0,q_m1} = 10 -> alu_op=10, alu_en=1.
  - {q0,q_m1} = 01 -> alu_op=01, alu_en=1.
  - 00 or 11 -> alu_op=00, alu_en=0.
  - Next state: SHIFT.
- SHIFT: shift_en=1, iter_cnt <= iter_cnt-1. If iter_cnt==1 -> OUT, else -> EVAL.
- OUT: load_out=1; -> DONE.
- DONE: done=1, busy=0; -> IDLE unconditionally. start held high is accepted in the following IDLE cycle.
- alu_op=00 and alu_en=0 in every state other than EVAL.
- ld_ops, shift_en, load_out and done are each high only in their own state.
- Timing: call edge E0 the edge that samples start.
  - ld_ops is high in cycle 1 after E0.
  - Iteration k has EVAL in cycle 2k and SHIFT in cycle 2k+1 (k = 1..N).
  - load_out is high in cycle 2N+2; done in cycle 2N+3.
  - busy is high in cycles 1..2N+2.
  - Earliest next ld_ops is cycle 2N+5.
- start while busy or in DONE: ignored; no queuing.
- abort=1 at an edge in LOAD/EVAL/SHIFT/OUT/DONE:
  - -> IDLE, iter_cnt <= 0.
  - No load_out or done is issued afterwards.
  - abort in OUT still lets that cycle's load_out occur, but suppresses done.
  - abort has priority over all other transitions except reset.
  - abort in IDLE has no effect; start is still honoured.
- Simultaneous start and abort in IDLE -> LOAD.
- iter_cnt never wraps. It only decrements in SHIFT, and SHIFT with iter_cnt==1 always exits.

Test Plan:
- Async reset: drive rst=0 between edges during EVAL of iteration 3 -> all outputs 0 before the next edge. After release, state is IDLE and iter_cnt=0. No load_out or done follows.
- N=8, q0=q_m1=0 throughout, start pulsed 1 cycle -> ld_ops in cycle 1. 8 EVAL cycles with alu_en=0. 8 shift_en pulses (cycles 3,5,...,17). load_out in cycle 18, done in cycle 19. busy is high exactly in cycles 1-18.
- N=8, bench models Q for multiplier 0x55 (Q-1 starts 0) -> alu_op sequence 10,01,10,01,10,01,10,01. alu_en=1 on all 8 EVAL cycles. iter_cnt reads 8..1 in successive EVALs.
- start held high continuously -> first done in cycle 19. IDLE in cycle 20. Second ld_ops in cycle 21. No pulse is duplicated.
- abort=1 during EVAL of iteration 3 -> IDLE next cycle, busy=0. No load_out or done. A start pulse asserted during the busy period beforehand produced no effect.
- N=4 build, q pattern all 11 -> alu_en never asserted. load_out in cycle 10, done in cycle 11.
